tdm_demux4: RTL

//  Receive-side partner of the 4:1 channel mux: takes one time-multiplexed sample stream
//  and rebuilds the four channel values, framed by frame_sync (slot 0).

---
 rtl/tdm_pkg.sv | 6 +
 rtl/tdm_slot_ctr.sv | 21 ++
 rtl/tdm_demux4.sv | 103 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared TDM framing types used by both the mux-side framer and the demux.
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    typedef logic [1:0] slot_t;
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit wrapping slot counter with sync clear, load-to-1 and increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t cnt
);
    slot_t cnt_q;
    always_ff @(posedge clk) begin
        if (clr)
            cnt_q <= '0;
        else if (load1)
            cnt_q <= slot_t'(1);
        else if (inc)
            cnt_q <= cnt_q + slot_t'(1);
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds four channels from a frame_sync-aligned TDM sample stream,
// staging slots 0..2 and publishing all four together on the slot-3 sample.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             sync_err
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] stg_q [NUM_SLOTS-1];
    logic [WIDTH-1:0] stg_d [NUM_SLOTS-1];
    logic [WIDTH-1:0] ch_q  [NUM_SLOTS];
    logic [WIDTH-1:0] ch_d  [NUM_SLOTS];
    logic             fv_q, fv_d;
    logic             se_q, se_d;
    logic             load1, inc;
    slot_t            sel_q;

    tdm_slot_ctr u_ctr (
        .clk  (clk),
        .clr  (rst),
        .load1(load1),
        .inc  (inc),
        .cnt  (sel_q)
    );

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        ch_d    = ch_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        load1   = 1'b0;
        inc     = 1'b0;
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    stg_d[0] = din;
                    stg_d[1] = '0;
                    stg_d[2] = '0;
                    load1    = 1'b1;
                    state_d  = LOCKED;
                end
            end else if (frame_sync && sel_q != slot_t'(0)) begin
                // misplaced sync: drop the partial frame and restart at slot 0
                se_d     = 1'b1;
                stg_d[0] = din;
                stg_d[1] = '0;
                stg_d[2] = '0;
                load1    = 1'b1;
            end else if (sel_q == slot_t'(NUM_SLOTS - 1)) begin
                ch_d[0] = stg_q[0];
                ch_d[1] = stg_q[1];
                ch_d[2] = stg_q[2];
                ch_d[3] = din;
                fv_d    = 1'b1;
                inc     = 1'b1;
            end else begin
                stg_d[sel_q] = din;
                inc          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQUIRE_SYNC ? HUNT : LOCKED;
            stg_q   <= '{default: '0};
            ch_q    <= '{default: '0};
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            ch_q    <= ch_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign sel         = sel_q;
    assign locked      = (state_q == LOCKED);
endmodule
